// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings,
// palette index width and the palette lookup.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'b00,
    MODE_CHASE = 2'b01,
    MODE_WIPE  = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  localparam int PAL_IND_W = 2;

  // Palette entry packed {ch2,ch1,ch0}; each channel is either level or zero.
  function automatic logic [23:0] palette(input logic [7:0] level,
                                          input logic [PAL_IND_W-1:0] ind);
    logic [23:0] entry;
    case (ind)
      2'd0:    entry = {level, 8'h00, 8'h00};
      2'd1:    entry = {8'h00, level, 8'h00};
      2'd2:    entry = {8'h00, 8'h00, level};
      default: entry = {level, level, level};
    endcase
    return entry;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler: one single-cycle tick every 2**PERIOD_BITS clocks,
// asserted while the counter is all-ones.
module led_prescaler #(
  parameter int PERIOD_BITS = 19
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [PERIOD_BITS-1:0] count;

  // Counter wraps naturally; it runs independently of the pattern enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + 1'b1;
  end

  assign tick = &count;

endmodule

// File: rtl/led_pattern_gen.sv
// LED strip pattern generator: walks NUM_LEDS pixels, one pixel write per
// prescaler period, in solid / chase / wipe / off modes from a 4-entry palette.
// Optional macro LED_BRIGHT_EN adds a 3-bit brightness input that right-shifts
// every channel; it is sampled together with mode at the frame boundary.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int         NUM_LEDS    = 60,
  parameter int         IDX_W       = 8,
  parameter int         PERIOD_BITS = 19,
  parameter logic [7:0] LEVEL       = 8'h10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
`ifdef LED_BRIGHT_EN
  input  logic [2:0]       brightness,
`endif
  output logic [IDX_W-1:0] led_num,
  output logic [23:0]      rgb_data,
  output logic             write
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LEDS - 1);

  logic tick;

  led_prescaler #(
    .PERIOD_BITS(PERIOD_BITS)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Frame state
  logic [IDX_W-1:0]     idx, idx_next;
  logic [IDX_W-1:0]     pos, pos_next;
  logic [PAL_IND_W-1:0] color_ind, color_next;
  mode_e                active_mode, mode_next;
  logic [IDX_W-1:0]     led_next;
  logic [23:0]          rgb_next;
  logic                 write_next;

  // Per-write decode
  logic                 frame_start;
  logic                 frame_last;
  logic                 mode_change;
  mode_e                frame_mode;
  logic [IDX_W-1:0]     frame_pos;
  logic                 pixel_on;
  logic [23:0]          base_colour;
  logic [23:0]          pixel_colour;

`ifdef LED_BRIGHT_EN
  logic [2:0] bright, bright_next, frame_bright;

  // Per-channel logical right shift; channels never borrow from each other.
  function automatic logic [23:0] dim(input logic [23:0] c, input logic [2:0] sh);
    return {c[23:16] >> sh, c[15:8] >> sh, c[7:0] >> sh};
  endfunction
`endif

  // Registered frame state and output strobe; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      pos         <= '0;
      color_ind   <= '0;
      active_mode <= MODE_SOLID;
      led_num     <= '0;
      rgb_data    <= '0;
      write       <= 1'b0;
`ifdef LED_BRIGHT_EN
      bright      <= '0;
`endif
    end else begin
      idx         <= idx_next;
      pos         <= pos_next;
      color_ind   <= color_next;
      active_mode <= mode_next;
      led_num     <= led_next;
      rgb_data    <= rgb_next;
      write       <= write_next;
`ifdef LED_BRIGHT_EN
      bright      <= bright_next;
`endif
    end
  end

  // Colour of the pixel at idx. Mode (and brightness) are taken from the
  // inputs on the first pixel of a frame and held for the rest of it, so a
  // frame is never mixed; a mode change restarts pos at 0 for that frame.
  always_comb begin
    frame_start  = (idx == '0);
    frame_last   = (idx == LAST);
    mode_change  = frame_start && (mode_e'(mode) != active_mode);
    frame_mode   = frame_start ? mode_e'(mode) : active_mode;
    frame_pos    = mode_change ? '0 : pos;
    base_colour  = palette(LEVEL, color_ind);
    case (frame_mode)
      MODE_SOLID: pixel_on = 1'b1;
      MODE_CHASE: pixel_on = (idx == frame_pos);
      MODE_WIPE:  pixel_on = (idx <= frame_pos);
      default:    pixel_on = 1'b0;
    endcase
`ifdef LED_BRIGHT_EN
    frame_bright = frame_start ? brightness : bright;
    pixel_colour = pixel_on ? dim(base_colour, frame_bright) : 24'h000000;
`else
    pixel_colour = pixel_on ? base_colour : 24'h000000;
`endif
  end

  // Next-state: on an enabled tick issue the write, step idx and apply the
  // frame-end pos/colour updates; a disabled tick freezes everything.
  always_comb begin
    idx_next    = idx;
    pos_next    = pos;
    color_next  = color_ind;
    mode_next   = active_mode;
    led_next    = led_num;
    rgb_next    = rgb_data;
    write_next  = 1'b0;
`ifdef LED_BRIGHT_EN
    bright_next = bright;
`endif
    if (tick && enable) begin
      write_next = 1'b1;
      led_next   = idx;
      rgb_next   = pixel_colour;
      idx_next   = frame_last ? '0 : idx + 1'b1;
      if (frame_start) begin
        mode_next = frame_mode;
        pos_next  = frame_pos;
`ifdef LED_BRIGHT_EN
        bright_next = frame_bright;
`endif
      end
      // NUM_LEDS >= 2, so the first and last pixel of a frame never coincide.
      if (frame_last && (frame_mode != MODE_OFF)) begin
        pos_next = (pos == LAST) ? '0 : pos + 1'b1;
        if ((frame_mode == MODE_SOLID) || (pos == LAST))
          color_next = color_ind + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen with NUM_LEDS=4, PERIOD_BITS=2,
// LEVEL=8'h10. Define LED_BRIGHT_EN to also exercise the brightness input.
module tb_led_pattern_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  led_num;
  logic [23:0] rgb_data;
  logic        write;
`ifdef LED_BRIGHT_EN
  logic [2:0]  brightness = 3'd0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int violations = 0;
  logic prev_write = 1'b0;

  led_pattern_gen #(
    .NUM_LEDS(4), .IDX_W(8), .PERIOD_BITS(2), .LEVEL(8'h10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .mode    (mode),
`ifdef LED_BRIGHT_EN
    .brightness(brightness),
`endif
    .led_num (led_num),
    .rgb_data(rgb_data),
    .write   (write)
  );

  always #5 clk = ~clk;

  // Protocol watch: no back-to-back strobes, index never reaches NUM_LEDS.
  always @(negedge clk) begin
    if (!reset) begin
      if (write && prev_write) violations++;
      if (write && led_num >= 8'd4) violations++;
      prev_write = write;
    end else begin
      prev_write = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int i);
    case (i % 4)
      0:       return 24'h100000;
      1:       return 24'h001000;
      2:       return 24'h000010;
      default: return 24'h101010;
    endcase
  endfunction

  task automatic wait_write(output logic [7:0] led, output logic [23:0] rgb);
    bit found = 0;
    led = 8'hff;
    rgb = 24'h0;
    for (int i = 0; i < 32 && !found; i++) begin
      @(negedge clk);
      if (write) begin
        found = 1;
        led = led_num;
        rgb = rgb_data;
      end
    end
    if (!found) check("write_timeout", 0, 1);
  endtask

  task automatic do_reset(input logic [1:0] m);
    reset = 1'b1;
    mode = m;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0]  led;
    logic [23:0] rgb;
    logic [23:0] exp;
    int cnt;

    // Reset state
    @(negedge clk);
    check("rst_led", led_num, 0);
    check("rst_rgb", rgb_data, 0);
    check("rst_write", write, 0);

    // 1: solid colour cycle
    do_reset(2'b00);
    for (int k = 0; k < 20; k++) begin
      wait_write(led, rgb);
      check($sformatf("solid_led%0d", k), led, k % 4);
      check($sformatf("solid_rgb%0d", k), rgb, pal(k / 4));
    end

    // 2: chase
    do_reset(2'b01);
    for (int k = 0; k < 20; k++) begin
      wait_write(led, rgb);
      exp = ((k % 4) == ((k / 4) % 4)) ? ((k < 16) ? 24'h100000 : 24'h001000) : 24'h0;
      check($sformatf("chase_rgb%0d", k), rgb, exp);
    end

    // 3: wipe, then switch to off mid-frame, then to chase
    do_reset(2'b10);
    for (int k = 0; k < 12; k++) begin
      wait_write(led, rgb);
      exp = ((k % 4) <= (k / 4)) ? 24'h100000 : 24'h0;
      check($sformatf("wipe_rgb%0d", k), rgb, exp);
    end
    wait_write(led, rgb);
    check("wipe_f3_p0", rgb, 24'h100000);
    wait_write(led, rgb);
    check("wipe_f3_p1", rgb, 24'h100000);
    mode = 2'b11;
    wait_write(led, rgb);
    check("wipe_f3_p2", rgb, 24'h100000);
    wait_write(led, rgb);
    check("wipe_f3_p3", rgb, 24'h100000);
    wait_write(led, rgb);
    check("off_p0_led", led, 0);
    check("off_p0", rgb, 0);
    mode = 2'b01;
    for (int k = 1; k < 4; k++) begin
      wait_write(led, rgb);
      check($sformatf("off_p%0d", k), rgb, 0);
    end
    for (int k = 0; k < 4; k++) begin
      wait_write(led, rgb);
      check($sformatf("post_off_chase_p%0d", k), rgb, (k == 0) ? 24'h001000 : 24'h0);
    end

    // 4: enable dropped at idx 2
    do_reset(2'b00);
    wait_write(led, rgb);
    wait_write(led, rgb);
    check("en_pre_led", led, 1);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write) cnt++;
    end
    check("en_frozen_writes", cnt, 0);
    enable = 1'b1;
    wait_write(led, rgb);
    check("en_resume_led", led, 2);
    check("en_resume_rgb", rgb, 24'h100000);

    // 5: async reset during a write cycle
    do_reset(2'b00);
    for (int k = 0; k < 6; k++) wait_write(led, rgb);
    check("ar_pre_rgb", rgb, 24'h001000);
    #1 reset = 1'b1;
    #1;
    check("ar_write", write, 0);
    check("ar_rgb", rgb_data, 0);
    check("ar_led", led_num, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_write(led, rgb);
    check("ar_first_led", led, 0);
    check("ar_first_rgb", rgb, 24'h100000);

`ifdef LED_BRIGHT_EN
    // 6: brightness
    brightness = 3'd3;
    do_reset(2'b00);
    wait_write(led, rgb);
    check("br_p0", rgb, 24'h020000);
    wait_write(led, rgb);
    brightness = 3'd0;
    wait_write(led, rgb);
    check("br_p2_held", rgb, 24'h020000);
    wait_write(led, rgb);
    check("br_p3_held", rgb, 24'h020000);
    wait_write(led, rgb);
    check("br_next_frame", rgb, 24'h001000);
`endif

    check("write_protocol", violations, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
